page_stream_src: RTL and testbench
==================================

PAGE_STREAM_SRC -- requirements
Module: page_stream_src

Interface
REQ-001 SHALL have parameter DW, default 9: token data width, matching page stream data fields.
REQ-002 SHALL have parameter LW, default 8: width of the burst-length field.
REQ-003 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port cmd_start, input, 1: request a new burst; sampled only in IDLE.
REQ-006 SHALL have port cmd_base, input, DW: first data value of the burst.
REQ-007 SHALL have port cmd_len, input, LW: number of data tokens before the EOS token.
REQ-008 SHALL have port cmd_busy, output, 1: high whenever the FSM is not in IDLE.
REQ-009 SHALL have port done, output, 1: one-cycle pulse after the EOS token transfers.
REQ-010 SHALL have port s_d, output, DW: token data, driving a page queue qin data input.
REQ-011 SHALL have port s_e, output, 1: end-of-stream flag of the token.
REQ-012 SHALL have port s_v, output, 1: token valid.
REQ-013 SHALL have port s_b, input, 1: back-pressure from the queue; high means the token is not accepted.

Function
REQ-014 SHALL transfer a token on a rising edge exactly when s_v=1 and s_b=0 in that cycle.
REQ-015 SHALL hold s_d, s_e and s_v stable while s_v=1 and s_b=1; no token is dropped or altered under back-pressure.
REQ-016 SHALL implement the FSM states IDLE, DATA and EOS.
REQ-017 SHALL transition IDLE->DATA on cmd_start=1 with cmd_len>0, latching cmd_base into the data register and cmd_len into the remaining counter.
REQ-018 SHALL transition IDLE->EOS on cmd_start=1 with cmd_len=0, emitting only the EOS token.
REQ-019 SHALL, in DATA, drive s_v=1, s_e=0 and s_d=current value.
REQ-020 SHALL, in DATA on each transfer, increment the data value modulo 2^DW and decrement the remaining counter.
REQ-021 SHALL transition DATA->EOS on the transfer that decrements the remaining counter to zero.
REQ-022 SHALL, in EOS, drive s_v=1, s_e=1 and s_d=0.
REQ-023 SHALL transition EOS->IDLE on the EOS-token transfer and assert done for the following cycle only.
REQ-024 SHALL have registered outputs only, with no combinational path from s_b to s_v, s_d or s_e.
REQ-025 SHALL ignore cmd_start when not in IDLE; the in-flight burst is unaffected.
REQ-026 SHALL accept cmd_start=1 in the same cycle that done=1, starting the next burst so that s_v rises the following cycle.
REQ-027 SHALL deassert s_v the first cycle after the EOS transfer, in IDLE.
REQ-028 SHALL support cmd_len = 2^LW-1 without counter overflow; the counter is LW bits wide.
REQ-029 SHALL make the first token visible (s_v=1) the cycle after cmd_start is accepted.

Reset
REQ-030 SHALL, while reset=1, force state IDLE and s_v=0, s_e=0, s_d=0, cmd_busy=0, done=0, with the counter and data register cleared.
REQ-031 SHALL, on reset asserted mid-burst, abandon the burst without emitting EOS, and reset SHALL take priority over cmd_start.

Verification
REQ-032 SHALL cover: cmd_start with base=5, len=3, s_b=0 -> tokens (5,e0),(6,e0),(7,e0),(0,e1) on 4 consecutive cycles, done pulsed once, cmd_busy high for 4 cycles.
REQ-033 SHALL cover: base=511, len=2 -> data 511 then 0 (wrap), then EOS.
REQ-034 SHALL cover: len=0 -> a single (0,e1) token, then done.
REQ-035 SHALL cover: len=4 with s_b high on every odd cycle -> the sequence is unchanged, each token is held stable while blocked, and exactly 5 transfers occur.
REQ-036 SHALL cover: cmd_start pulsed mid-burst -> ignored; cmd_start in the done cycle -> the new burst begins the next cycle.
REQ-037 SHALL cover: reset asserted after 2 of 5 tokens -> s_v=0 the next cycle, no EOS emitted, cmd_busy=0.

Source files
------------

// File: rtl/page_stream_src.sv
//------------------------------------------------------------------------------
// page_stream_src : burst token source for a page queue (data tokens then EOS)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module page_stream_src #(
    parameter int DW = 9,
    parameter int LW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cmd_start,
    input  logic [DW-1:0] cmd_base,
    input  logic [LW-1:0] cmd_len,
    output logic          cmd_busy,
    output logic          done,
    output logic [DW-1:0] s_d,
    output logic          s_e,
    output logic          s_v,
    input  logic          s_b
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_EOS  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] data_q,  data_d;
    logic [LW-1:0] cnt_q,   cnt_d;
    logic          done_q,  done_d;
    logic          busy_q,  busy_d;
    logic          sv_q,    sv_d;
    logic          se_q,    se_d;
    logic [DW-1:0] sd_q,    sd_d;
    logic          xfer;

    assign xfer = sv_q & ~s_b;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            sv_q    <= 1'b0;
            se_q    <= 1'b0;
            sd_q    <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            sv_q    <= sv_d;
            se_q    <= se_d;
            sd_q    <= sd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    data_d  = cmd_base;
                    cnt_d   = cmd_len;
                    state_d = (cmd_len == '0) ? S_EOS : S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    data_d = data_q + DW'(1);
                    cnt_d  = cnt_q - LW'(1);
                    if (cnt_q == LW'(1)) begin
                        state_d = S_EOS;
                    end
                end
            end
            S_EOS: begin
                if (xfer) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave the block registered.
    always_comb begin
        sv_d   = (state_d != S_IDLE);
        busy_d = (state_d != S_IDLE);
        se_d   = (state_d == S_EOS);
        sd_d   = (state_d == S_DATA) ? data_d : '0;
    end

    assign cmd_busy = busy_q;
    assign done     = done_q;
    assign s_v      = sv_q;
    assign s_e      = se_q;
    assign s_d      = sd_q;

endmodule

`default_nettype wire

// File: tb/tb_page_stream_src.sv
//------------------------------------------------------------------------------
// tb_page_stream_src : vector table plus token scoreboard for page_stream_src
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_page_stream_src;

    localparam int DW = 9;
    localparam int LW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          cmd_start;
    logic [DW-1:0] cmd_base;
    logic [LW-1:0] cmd_len;
    logic          cmd_busy;
    logic          done;
    logic [DW-1:0] s_d;
    logic          s_e;
    logic          s_v;
    logic          s_b;

    int total = 0;
    int bad   = 0;
    logic [DW:0] sb_q[$];

    page_stream_src #(.DW(DW), .LW(LW)) dut (
        .clock(clock), .reset(reset), .cmd_start(cmd_start), .cmd_base(cmd_base),
        .cmd_len(cmd_len), .cmd_busy(cmd_busy), .done(done), .s_d(s_d),
        .s_e(s_e), .s_v(s_v), .s_b(s_b)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] base;
        logic [LW-1:0] len;
        bit            bp;
        bit            poke;
        bit            chain;
        int            exp_xfers;
        int            exp_busy;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Entered and left at a negedge; leaves in the cycle where done is high.
    task automatic run_burst(input vec_t v);
        int          xfers = 0;
        int          busy  = 0;
        int          dones = 0;
        int          cyc   = 0;
        bit          held  = 0;
        logic [DW-1:0] hd  = '0;
        logic        he    = 1'b0;
        logic [DW:0] tok;
        for (int i = 0; i < int'(v.len); i++) begin
            sb_q.push_back({1'b0, DW'(int'(v.base) + i)});
        end
        sb_q.push_back({1'b1, {DW{1'b0}}});
        cmd_base  = v.base;
        cmd_len   = v.len;
        cmd_start = 1'b1;
        @(posedge clock); #1;
        cmd_start = 1'b0;
        while (1) begin
            s_b = v.bp ? (cyc % 2 == 1) : 1'b0;
            if (v.poke) begin
                cmd_start = (cyc == 1);
                cmd_base  = 9'd99;
                cmd_len   = 8'd7;
            end
            @(negedge clock);
            if (cyc == 0) check("first_valid", s_v, 1);
            busy  += int'(cmd_busy);
            dones += int'(done);
            if (held) begin
                check("hold_v", s_v, 1);
                check("hold_d", s_d, hd);
                check("hold_e", s_e, he);
            end
            if (s_v && !s_b) begin
                xfers++;
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    tok = sb_q.pop_front();
                    check("tok_d", s_d, tok[DW-1:0]);
                    check("tok_e", s_e, tok[DW]);
                end
            end
            held = s_v && s_b;
            hd   = s_d;
            he   = s_e;
            if (done) begin
                check("idle_after_eos", s_v, 0);
                break;
            end
            if (cyc >= 1000) begin
                check("timeout", 1, 0);
                break;
            end
            @(posedge clock); #1;
            cyc++;
        end
        cmd_start = 1'b0;
        check("xfers", xfers, v.exp_xfers);
        check("busy_cycles", busy, v.exp_busy);
        check("done_pulses", dones, 1);
        check("sb_empty", sb_q.size(), 0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{9'd5,   8'd3,   1'b0, 1'b0, 1'b0, 4,   4};
        vecs[1] = '{9'd511, 8'd2,   1'b0, 1'b0, 1'b0, 3,   3};
        vecs[2] = '{9'd77,  8'd0,   1'b0, 1'b0, 1'b0, 1,   1};
        vecs[3] = '{9'd10,  8'd4,   1'b1, 1'b0, 1'b0, 5,   9};
        vecs[4] = '{9'd20,  8'd3,   1'b0, 1'b1, 1'b0, 4,   4};
        vecs[5] = '{9'd300, 8'd255, 1'b0, 1'b0, 1'b1, 256, 256};

        reset = 1'b1; cmd_start = 1'b0; cmd_base = '0; cmd_len = '0; s_b = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_sv",   s_v, 0);
        check("rst_se",   s_e, 0);
        check("rst_sd",   s_d, 0);
        check("rst_busy", cmd_busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_sv", s_v, 0);

        foreach (vecs[i]) begin
            if (!vecs[i].chain) @(negedge clock);
            run_burst(vecs[i]);
        end
        // Back-to-back: the next burst is requested in the done cycle of the previous one.
        run_burst('{9'd1, 8'd1, 1'b0, 1'b0, 1'b1, 2, 2});
        @(negedge clock);
        check("done_single", done, 0);

        // Reset after two of five tokens.
        cmd_base = 9'd40; cmd_len = 8'd5; cmd_start = 1'b1;
        @(posedge clock); #1;
        cmd_start = 1'b0;
        @(negedge clock);
        check("rb_tok0", s_d, 40);
        @(negedge clock);
        check("rb_tok1", s_d, 41);
        reset = 1'b1;
        cmd_start = 1'b1;
        @(negedge clock);
        check("rb_sv",   s_v, 0);
        check("rb_busy", cmd_busy, 0);
        check("rb_se",   s_e, 0);
        check("rb_sd",   s_d, 0);
        @(negedge clock);
        check("rb_prio", s_v, 0);
        reset = 1'b0;
        cmd_start = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("rb_no_eos", {s_v, s_e, done}, 0);
        end
        run_burst('{9'd8, 8'd2, 1'b0, 1'b0, 1'b1, 3, 3});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
